// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the memory controller.
// Holds the LSB op encodings, the RoB/LSB index widths, the controller state
// encodings and a helper that maps an op to its access length in bytes.
package mem_ctrl_pkg;

  localparam int unsigned ROB_ADDR_WIDTH = 4;
  localparam int unsigned LSB_ADDR_WIDTH = 4;

  localparam logic [5:0] Lb  = 6'd1;
  localparam logic [5:0] Lh  = 6'd2;
  localparam logic [5:0] Lw  = 6'd3;
  localparam logic [5:0] Lbu = 6'd4;
  localparam logic [5:0] Lhu = 6'd5;
  localparam logic [5:0] Sb  = 6'd6;
  localparam logic [5:0] Sh  = 6'd7;
  localparam logic [5:0] Sw  = 6'd8;

  typedef enum logic [1:0] {
    MC_IDLE,
    MC_READ,
    MC_WRITE,
    MC_DONE
  } mc_state_t;

  // Number of RAM byte cycles an LSB op needs; unknown ops act as words.
  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    case (op)
      Lb, Lbu, Sb: return 3'd1;
      Lh, Lhu, Sh: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// mem_byte_assembler: byte-lane capture register plus load extension.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : clear the word register at the start of an access
//   cap        : write din into byte lane `lane`
//   lane       : byte lane 0..3
//   din        : byte from the RAM
//   op         : load op selecting sign/zero extension
//   word       : raw little-endian assembled word
//   ext        : word extended according to op
module mem_byte_assembler
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cap,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  input  logic [5:0]  op,
  output logic [31:0] word,
  output logic [31:0] ext
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else if (start) begin
      word <= '0;
    end else if (cap) begin
      case (lane)
        2'd0:    word[7:0]   <= din;
        2'd1:    word[15:8]  <= din;
        2'd2:    word[23:16] <= din;
        default: word[31:24] <= din;
      endcase
    end
  end

  always_comb begin
    ext = word;
    case (op)
      Lb:      ext = {{24{word[7]}}, word[7:0]};
      Lh:      ext = {{16{word[15]}}, word[15:0]};
      Lbu:     ext = {24'd0, word[7:0]};
      Lhu:     ext = {16'd0, word[15:0]};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches into
// single-byte RAM cycles and returns a one-cycle done pulse to the requester.
// Optional feature macro: MEMCTRL_IO_STALL_EN -- hold a store byte aimed at
// the IO region (addr[17:16] == 2'b11) while io_buffer_full is high.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable), clear (flush)
//   lsb_request/lsb_load_or_store/lsb_op/lsb_addr/lsb_data -> lsb_done, lsb_rdata
//   if_request/if_addr -> if_done, if_inst
//   mem_din, mem_dout, mem_a, mem_wr : byte-wide RAM port
//   io_buffer_full : UART TX buffer full
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        lsb_request,
  input  logic        lsb_load_or_store,
  input  logic [5:0]  lsb_op,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_data,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,
  input  logic        if_request,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_t   state, state_nx;
  logic [31:0] addr_q, data_q;
  logic [5:0]  op_q;
  logic        store_q, from_lsb_q;
  logic [2:0]  cnt_q, cnt_nx, nbytes_q;
  logic        rdy_q, skip_q;
  logic        accept, cap, stall, done;
  logic [31:0] byte_addr, word, ext;

  assign byte_addr = addr_q + {29'd0, cnt_q};

`ifdef MEMCTRL_IO_STALL_EN
  assign stall = (state == MC_WRITE) && io_buffer_full && (byte_addr[17:16] == 2'b11);
`else
  // Input is deliberately ignored in this build.
  assign stall = 1'b0 & io_buffer_full;
`endif

  // The byte for the address shown in cycle c arrives in c+1. On the first
  // not-ready cycle that byte is still taken; skip_q then suppresses the
  // capture on the resume cycle so the frozen address is re-read next cycle.
  assign cap = (state == MC_READ) && (cnt_q != 3'd0) && !skip_q && (rdy_in || rdy_q);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_q;
    accept   = 1'b0;
    case (state)
      MC_IDLE: begin
        if (!clear && (lsb_request || if_request)) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          state_nx = (lsb_request && lsb_load_or_store) ? MC_WRITE : MC_READ;
        end
      end
      MC_READ: begin
        if (clear)                    state_nx = MC_IDLE;
        else if (cnt_q == nbytes_q)   state_nx = MC_DONE;
        else                          cnt_nx   = cnt_q + 3'd1;
      end
      MC_WRITE: begin
        if (!stall) begin
          if (cnt_q == nbytes_q - 3'd1) state_nx = MC_DONE;
          else                          cnt_nx   = cnt_q + 3'd1;
        end
      end
      default: state_nx = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= MC_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= '0;
      store_q    <= 1'b0;
      from_lsb_q <= 1'b0;
      nbytes_q   <= '0;
    end else if (rdy_in) begin
      state <= state_nx;
      cnt_q <= cnt_nx;
      if (accept) begin
        addr_q     <= lsb_request ? lsb_addr : if_addr;
        data_q     <= lsb_data;
        op_q       <= lsb_op;
        store_q    <= lsb_request && lsb_load_or_store;
        from_lsb_q <= lsb_request;
        nbytes_q   <= lsb_request ? op_bytes(lsb_op) : 3'd4;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdy_q  <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      rdy_q <= rdy_in;
      if (rdy_in)   skip_q <= 1'b0;
      else if (cap) skip_q <= 1'b1;
    end
  end

  mem_byte_assembler u_asm (
    .clk   (clk_in),
    .rst_n (rst_in),
    .start (accept && rdy_in),
    .cap   (cap),
    .lane  (cnt_q[1:0] - 2'd1),
    .din   (mem_din),
    .op    (op_q),
    .word  (word),
    .ext   (ext)
  );

  // A load completing while the RoB flushes is dropped; stores always report.
  assign done      = (state == MC_DONE) && (store_q || !clear);
  assign lsb_done  = done && from_lsb_q;
  assign if_done   = done && !from_lsb_q;
  assign lsb_rdata = (lsb_done && !store_q) ? ext : '0;
  assign if_inst   = if_done ? word : '0;

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == MC_READ && cnt_q < nbytes_q) begin
      mem_a = byte_addr;
    end else if (state == MC_WRITE) begin
      mem_a  = byte_addr;
      mem_wr = rdy_in && !stall;
      case (cnt_q[1:0])
        2'd0:    mem_dout = data_q[7:0];
        2'd1:    mem_dout = data_q[15:8];
        2'd2:    mem_dout = data_q[23:16];
        default: mem_dout = data_q[31:24];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a scoreboard of expected completions
// and RAM writes, checked by an independent monitor on the falling edge.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        lsb_request = 1'b0;
  logic        lsb_load_or_store = 1'b0;
  logic [5:0]  lsb_op = '0;
  logic [31:0] lsb_addr = '0;
  logic [31:0] lsb_data = '0;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        if_request = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_inst;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy_in), .clear(clear),
    .lsb_request(lsb_request), .lsb_load_or_store(lsb_load_or_store),
    .lsb_op(lsb_op), .lsb_addr(lsb_addr), .lsb_data(lsb_data),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .if_request(if_request), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  typedef struct { logic is_lsb; logic [31:0] data; int unsigned cyc; } resp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int unsigned cyc; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  int checks = 0;
  int failures = 0;
  int done_seen = 0;

  always @(negedge clk) begin
    resp_t r;
    wr_t   w;
    if (rst_n && (lsb_done || if_done)) begin
      done_seen++;
      checks++;
      if (rq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done cyc=%0d lsb_done=%b if_done=%b", cyc, lsb_done, if_done);
      end else begin
        r = rq.pop_front();
        if (r.is_lsb !== lsb_done || (r.is_lsb ? lsb_rdata : if_inst) !== r.data || cyc != r.cyc) begin
          failures++;
          $display("FAIL done_resp got lsb=%b data=%h cyc=%0d exp lsb=%b data=%h cyc=%0d",
                   lsb_done, r.is_lsb ? lsb_rdata : if_inst, cyc, r.is_lsb, r.data, r.cyc);
        end
      end
    end
    if (rst_n && mem_wr) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write cyc=%0d a=%h d=%h", cyc, mem_a, mem_dout);
      end else begin
        w = wq.pop_front();
        if (mem_a !== w.a || mem_dout !== w.d || cyc != w.cyc) begin
          failures++;
          $display("FAIL mem_write got a=%h d=%h cyc=%0d exp a=%h d=%h cyc=%0d",
                   mem_a, mem_dout, cyc, w.a, w.d, w.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Drive one LSB request at the start of a cycle (its cycle 0) and queue
  // the expected completion and, for stores, the expected byte writes.
  task automatic issue_lsb(input logic st, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp,
                           input int unsigned lat, input int unsigned wdly);
    int unsigned c0;
    int unsigned n;
    resp_t r;
    wr_t   w;
    @(posedge clk); #1;
    lsb_request = 1'b1; lsb_load_or_store = st; lsb_op = op; lsb_addr = a; lsb_data = d;
    c0 = cyc;
    r.is_lsb = 1'b1; r.data = exp; r.cyc = c0 + lat;
    rq.push_back(r);
    if (st) begin
      n = (op == Sb) ? 1 : (op == Sh) ? 2 : 4;
      for (int unsigned k = 0; k < n; k++) begin
        w.a = a + k; w.d = d[8*k +: 8]; w.cyc = c0 + 1 + k + wdly;
        wq.push_back(w);
      end
    end
  endtask

  task automatic wait_done(input logic lsb);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (lsb ? lsb_done : if_done) begin
        seen = 1'b1;
        if (lsb) lsb_request = 1'b0;
        else     if_request = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout lsb=%b got=none exp=pulse", lsb);
      lsb_request = 1'b0;
      if_request = 1'b0;
    end
  endtask

  task automatic lsb_op_full(input logic st, input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp, input int unsigned lat);
    issue_lsb(st, op, a, d, exp, lat, 0);
    wait_done(1'b1);
  endtask

  initial begin
    int unsigned c0;
    int snap;
    resp_t r;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0200] = 8'h80;
    ram[16'h0300] = 8'hFE; ram[16'h0301] = 8'h7F; ram[16'h0302] = 8'h01; ram[16'h0303] = 8'h90;
    ram[16'h0000] = 8'h93; ram[16'h0001] = 8'h01; ram[16'h0002] = 8'h50; ram[16'h0003] = 8'h00;
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    rst_n = 1'b1;

    lsb_op_full(1'b0, Lw,  32'h100, 32'h0, 32'h44332211, 6);
    lsb_op_full(1'b0, Lb,  32'h200, 32'h0, 32'hFFFFFF80, 3);
    lsb_op_full(1'b0, Lbu, 32'h200, 32'h0, 32'h00000080, 3);
    lsb_op_full(1'b0, Lh,  32'h300, 32'h0, 32'h00007FFE, 4);
    lsb_op_full(1'b0, Lh,  32'h302, 32'h0, 32'hFFFF9001, 4);
    lsb_op_full(1'b0, Lhu, 32'h302, 32'h0, 32'h00009001, 4);
    lsb_op_full(1'b1, Sh,  32'h3FF, 32'h0000ABCD, 32'h0, 3);
    lsb_op_full(1'b0, Lhu, 32'h3FF, 32'h0, 32'h0000ABCD, 4);
    lsb_op_full(1'b0, Lw,  32'hFFFFFFFE, 32'h0, 32'h0193BBAA, 6);

    // Simultaneous requests: LSB first, fetch accepted after lsb_done.
    @(posedge clk); #1;
    lsb_request = 1'b1; lsb_load_or_store = 1'b0; lsb_op = Lw; lsb_addr = 32'h100;
    if_request = 1'b1; if_addr = 32'h0;
    c0 = cyc;
    r.is_lsb = 1'b1; r.data = 32'h44332211; r.cyc = c0 + 6; rq.push_back(r);
    r.is_lsb = 1'b0; r.data = 32'h00500193; r.cyc = c0 + 13; rq.push_back(r);
    wait_done(1'b1);
    wait_done(1'b0);

    // Clear in cycle 2 of a fetch aborts it.
    @(posedge clk); #1;
    if_request = 1'b1; if_addr = 32'h0;
    snap = done_seen;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1; if_request = 1'b0;
    @(posedge clk);
    #1 clear = 1'b0;
    repeat (10) @(posedge clk);
    chk("clear_fetch_no_done", done_seen, snap);

    // Clear in cycle 1 of a store is ignored.
    issue_lsb(1'b1, Sw, 32'h500, 32'hDEADBEEF, 32'h0, 5, 0);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    wait_done(1'b1);
    lsb_op_full(1'b0, Lw, 32'h500, 32'h0, 32'hDEADBEEF, 6);

    // rdy_in low in cycles 3-4 of a word load: two-cycle delay, data intact.
    issue_lsb(1'b0, Lw, 32'h100, 32'h0, 32'h44332211, 8, 0);
    repeat (3) @(posedge clk);
    #1 rdy_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rdy_in = 1'b1;
    wait_done(1'b1);

    // Store to the IO region with the UART buffer full.
    io_buffer_full = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
    issue_lsb(1'b1, Sb, 32'h30000, 32'h5A, 32'h0, 5, 3);
    repeat (4) @(posedge clk);
    #1 io_buffer_full = 1'b0;
`else
    issue_lsb(1'b1, Sb, 32'h30000, 32'h5A, 32'h0, 2, 0);
`endif
    wait_done(1'b1);
    io_buffer_full = 1'b0;

    // Asynchronous reset in cycle 2 of a load.
    @(posedge clk); #1;
    lsb_request = 1'b1; lsb_load_or_store = 1'b0; lsb_op = Lw; lsb_addr = 32'h100;
    snap = done_seen;
    repeat (2) @(posedge clk);
    #1 chk("pre_reset_mem_a", mem_a, 32'h101);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_a", mem_a, 32'd0);
    chk("async_rst_lsb_done", {31'd0, lsb_done}, 32'd0);
    chk("async_rst_lsb_rdata", lsb_rdata, 32'd0);
    lsb_request = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    chk("async_rst_no_done", done_seen, snap);

    #1;
    chk("resp_queue_empty", rq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the core and the byte-wide unified RAM. It serves two requesters: the load/store buffer (loads, and stores issued at RoB head) and instruction fetch. It serialises each access into 1/2/4 single-byte RAM cycles, sign- or zero-extends load data, and returns a one-cycle completion pulse to the requester that was served.

## Interface
- No parameters. Op encodings (`Lb`, `Lh`, `Lw`, `Lbu`, `Lhu`, `Sb`, `Sh`, `Sw`) come from `const.v`.
- `clk_in` in 1: single clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global enable; when low, all registers hold.
- `clear` in 1: RoB flush.
- `lsb_request` in 1: LSB access request; level, held until `lsb_done`.
- `lsb_load_or_store` in 1: 0 = load, 1 = store.
- `lsb_op` in 6: op code.
- `lsb_addr` in 32: byte address.
- `lsb_data` in 32: store data, low bytes used.
- `lsb_done` out 1: one-cycle completion pulse.
- `lsb_rdata` out 32: extended load data; 0 for stores.
- `if_request` in 1: fetch request; level, held until `if_done`.
- `if_addr` in 32: fetch address.
- `if_done` out 1: one-cycle fetch completion pulse.
- `if_inst` out 32: fetched word, little-endian.
- `mem_din` in 8: RAM read byte.
- `mem_dout` out 8: RAM write byte.
- `mem_a` out 32: RAM address.
- `mem_wr` out 1: 1 = write.
- `io_buffer_full` in 1: UART TX buffer full.

## Operation
- States:
  - IDLE: accepts a request.
  - READ: used for fetches and loads.
  - WRITE: used for stores.
  - DONE: asserts the done pulse for exactly one cycle, then returns to IDLE. It accepts nothing, so the requester can drop its level request.
- Arbitration in IDLE: `lsb_request` beats `if_request`. Address, op, data and requester id are latched at accept.
- Byte count `n`:
  - Lb, Lbu, Sb: 1.
  - Lh, Lhu, Sh: 2.
  - Lw, Sw, fetch: 4.
- Byte `k` uses address `addr + k`, computed 32-bit with wrap-around. Misaligned accesses are legal.
- Reads: byte `k` is returned on `mem_din` the cycle after its address is presented and is placed at bits `[8k+7:8k]`.
- Load extension:
  - Lb, Lh: sign-extend from bit 7 or bit 15.
  - Lbu, Lhu: zero-extend.
- Stores: `mem_dout` carries `lsb_data[8k+7:8k]` with `mem_wr` = 1.
- `clear`:
  - In READ: aborts the access and goes to IDLE; no done pulse, `mem_wr` = 0.
  - In WRITE or DONE-of-store: ignored; the store completes.
  - In IDLE: nothing is accepted that cycle.
- `rdy_in` low:
  - State, counters and outputs freeze, and `mem_wr` is gated to 0.
  - A read byte due in the first not-ready cycle is still captured, so no byte is lost.
- Reset values: all outputs 0, state IDLE. Asynchronous reset mid-access abandons the access with no done pulse.

## Timing
- Cycle 0 is the IDLE cycle in which the request is seen.
- Read of `n` bytes:
  - `mem_a` = `addr+k-1` in cycles 1..n.
  - Bytes are captured at the end of cycles 2..n+1.
  - Done in cycle n+2, so a fetch completes in cycle 6.
- Store of `n` bytes:
  - `mem_wr` = 1 in cycles 1..n.
  - Done in cycle n+1.
- The next accept is possible no earlier than the cycle after DONE.
- `lsb_rdata` and `if_inst` are valid only while the matching done is high.

## Configuration
- `MEMCTRL_IO_STALL_EN` defined:
  - Applies to a store byte whose address has `addr[17:16]` = 2'b11.
  - While `io_buffer_full` = 1, that byte is held in WRITE with `mem_wr` = 0 and the same address; the write resumes when the input drops.
  - Done is delayed by the stall length.
- Undefined: `io_buffer_full` is ignored and the timing above is exact.

## Structure
- Op codes and the `RoB_addr`/`LSB_addr` widths stay in `const.v`.
- Add state encodings `MC_IDLE`, `MC_READ`, `MC_WRITE`, `MC_DONE` there.
- One natural sub-module, `mem_byte_assembler`: the byte-lane capture register plus sign/zero-extension.

## Test plan
- **LSB Lw, addr 0x100:** RAM holds 0x11,0x22,0x33,0x44 at 0x100.. → `lsb_done` in cycle 6 with `lsb_rdata` = 0x44332211.
- **LSB Lb, addr 0x200:** RAM holds 0x80 → `lsb_rdata` = 0xFFFFFF80 in cycle 3. Same access as Lbu → 0x00000080.
- **LSB Sh, addr 0x3FF, data 0xABCD:** `mem_wr` in cycles 1–2 writing 0xCD@0x3FF then 0xAB@0x400; `lsb_done` in cycle 3.
- **Simultaneous `if_request` (0x0) and LSB Lw (0x100):** LSB served first. Fetch accepted the cycle after `lsb_done`, `if_done` 7 cycles later. No double accept.
- **Clear mid-operation:** `clear` in cycle 2 of a fetch → IDLE, no `if_done`. `clear` in cycle 1 of Sw → all four bytes written, `lsb_done` in cycle 5.
- **Stall on IO store** (`MEMCTRL_IO_STALL_EN` defined): Sb to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` = 0 for 3 cycles, then write 1, done 1 cycle later. Asynchronous reset mid-load → all outputs 0 immediately.
